// File: rtl/stepper_move_sequencer_if.sv
// rtl/stepper_move_sequencer_if.sv - command handshake bundle for the move sequencer
interface stepper_move_sequencer_if #(
    parameter int COUNT_BITS_X = 8,
    parameter int COUNT_BITS_Y = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [COUNT_BITS_X-1:0] cmd_x;
    logic [COUNT_BITS_Y-1:0] cmd_y;

    modport master (
        output cmd_valid,
        output cmd_x,
        output cmd_y,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_x,
        input  cmd_y,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_move_sequencer.sv
// rtl/stepper_move_sequencer.sv - queued (x,y) move scheduler driving StepperCtrlXY trigger/done
module stepper_move_sequencer #(
    parameter  int COUNT_BITS_X = 8,
    parameter  int COUNT_BITS_Y = 8,
    parameter  int DEPTH        = 4,
    localparam int LW           = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    stepper_move_sequencer_if.slave cmd,
    input  logic                    flush,
    input  logic                    stepper_done,
    output logic                    stepper_trigger,
    output logic [COUNT_BITS_X-1:0] stepper_num_steps_x,
    output logic [COUNT_BITS_Y-1:0] stepper_num_steps_y,
    output logic [LW-1:0]           level,
    output logic                    busy,
    output logic [15:0]             moves_done
);
    localparam int PW = LW - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state;

    logic [COUNT_BITS_X-1:0] fifo_x [DEPTH];
    logic [COUNT_BITS_Y-1:0] fifo_y [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_zero;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign cmd.cmd_ready = !full && !flush;
    assign push      = cmd.cmd_valid && cmd.cmd_ready;
    // flush wins over a same-edge pop; an empty queue never pops, so no bypass
    assign pop       = clk_en && (state == S_IDLE) && !empty && stepper_done && !flush;
    assign head_zero = (fifo_x[rd_ptr] == '0) && (fifo_y[rd_ptr] == '0);
    assign busy      = (state != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr] <= cmd.cmd_x;
            fifo_y[wr_ptr] <= cmd.cmd_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Trigger is registered alongside the state so it is high exactly while in ISSUE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= S_IDLE;
            stepper_trigger     <= 1'b0;
            stepper_num_steps_x <= '0;
            stepper_num_steps_y <= '0;
            moves_done          <= 16'd0;
        end else if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        stepper_num_steps_x <= fifo_x[rd_ptr];
                        stepper_num_steps_y <= fifo_y[rd_ptr];
                        if (head_zero) begin
                            moves_done <= moves_done + 16'd1;
                        end else begin
                            state           <= S_ISSUE;
                            stepper_trigger <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state           <= S_WAIT;
                    stepper_trigger <= 1'b0;
                end
                S_WAIT: begin
                    if (stepper_done) begin
                        moves_done <= moves_done + 16'd1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state           <= S_IDLE;
                    stepper_trigger <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stepper_move_sequencer.sv
// tb/tb_stepper_move_sequencer.sv - scoreboard bench for stepper_move_sequencer
module tb_stepper_move_sequencer;
    localparam int XB    = 8;
    localparam int YB    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          flush;
    logic          stepper_done;
    logic          stepper_trigger;
    logic [XB-1:0] stepper_num_steps_x;
    logic [YB-1:0] stepper_num_steps_y;
    logic [LW-1:0] level;
    logic          busy;
    logic [15:0]   moves_done;

    stepper_move_sequencer_if #(.COUNT_BITS_X(XB), .COUNT_BITS_Y(YB)) cmd_if ();

    stepper_move_sequencer #(.COUNT_BITS_X(XB), .COUNT_BITS_Y(YB), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .clk_en              (clk_en),
        .cmd                 (cmd_if.slave),
        .flush               (flush),
        .stepper_done        (stepper_done),
        .stepper_trigger     (stepper_trigger),
        .stepper_num_steps_x (stepper_num_steps_x),
        .stepper_num_steps_y (stepper_num_steps_y),
        .level               (level),
        .busy                (busy),
        .moves_done          (moves_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XB-1:0] x;
        logic [YB-1:0] y;
    } cmd_t;

    typedef struct packed {
        logic [LW-1:0] level;
        logic          ready;
        logic          busy;
        logic          trig;
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic [15:0]   moves;
    } stat_t;

    int total = 0;
    int bad   = 0;

    // Reference: a queue of accepted commands plus the phase of the current move
    cmd_t        mq[$];
    cmd_t        exp_trig[$];
    stat_t       exp_stat[$];
    int          ph = 0;           // 0 idle, 1 trigger period, 2 waiting for done
    logic [XB-1:0] m_x = '0;
    logic [YB-1:0] m_y = '0;
    logic [15:0] m_moves = 16'd0;
    bit          m_pushed = 0;

    // Stepper stand-in and clk_en pattern
    int cyc      = 0;
    int en_div   = 4;              // 0 selects random clk_en
    int st_cnt   = 0;
    int st_dur   = 5;
    bit hold_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        total++;
        bad++;
        $display("FAIL %s bound expired", name);
    endtask

    function automatic void model_step();
        cmd_t  c;
        stat_t s;
        bit    ok;
        ok       = (mq.size() < DEPTH) && !flush;
        m_pushed = cmd_if.cmd_valid && ok;
        if (clk_en) begin
            if (ph == 0) begin
                if (mq.size() != 0 && stepper_done && !flush) begin
                    c   = mq.pop_front();
                    m_x = c.x;
                    m_y = c.y;
                    if (c.x == '0 && c.y == '0) begin
                        m_moves = m_moves + 16'd1;
                    end else begin
                        ph = 1;
                        exp_trig.push_back(c);
                    end
                end
            end else if (ph == 1) begin
                ph = 2;
            end else if (stepper_done) begin
                ph      = 0;
                m_moves = m_moves + 16'd1;
            end
        end
        if (flush) mq.delete();
        if (m_pushed) begin
            c.x = cmd_if.cmd_x;
            c.y = cmd_if.cmd_y;
            mq.push_back(c);
        end
        s.level = LW'(mq.size());
        s.ready = (mq.size() < DEPTH) && !flush;
        s.busy  = (ph != 0) || (mq.size() != 0);
        s.trig  = (ph == 1);
        s.x     = m_x;
        s.y     = m_y;
        s.moves = m_moves;
        exp_stat.push_back(s);
    endfunction

    task automatic tick();
        bit trig_pre;
        bit en_pre;
        trig_pre = (ph == 1);
        @(posedge clk);
        en_pre = clk_en;
        model_step();
        if (en_pre) begin
            if (st_cnt > 0) st_cnt--;
            if (trig_pre) st_cnt = st_dur;
        end
        @(negedge clk);
        stepper_done = hold_done ? 1'b0 : (st_cnt == 0);
        cyc++;
        if (en_div == 0) clk_en = ($urandom_range(0, 1) == 1);
        else             clk_en = ((cyc % en_div) == 0);
    endtask

    task automatic push_cmd(input logic [XB-1:0] x, input logic [YB-1:0] y);
        int n;
        n = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_x     = x;
        cmd_if.cmd_y     = y;
        do begin
            tick();
            n++;
        end while (!m_pushed && n < 500);
        if (!m_pushed) fail_note("push_accept");
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((ph != 0 || mq.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) fail_note("wait_idle");
        tick();
        tick();
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (ph != p && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) fail_note("wait_phase");
    endtask

    // Monitor: per-edge status plus an in-order check of each trigger's step counts
    initial begin
        stat_t s;
        cmd_t  e;
        logic  prev_trig;
        prev_trig = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (exp_stat.size() != 0) begin
                s = exp_stat.pop_front();
                check("level",      32'(level),               32'(s.level));
                check("cmd_ready",  32'(cmd_if.cmd_ready),    32'(s.ready));
                check("busy",       32'(busy),                32'(s.busy));
                check("trigger",    32'(stepper_trigger),     32'(s.trig));
                check("steps_x",    32'(stepper_num_steps_x), 32'(s.x));
                check("steps_y",    32'(stepper_num_steps_y), 32'(s.y));
                check("moves_done", 32'(moves_done),          32'(s.moves));
            end
            if (stepper_trigger === 1'b1 && prev_trig !== 1'b1) begin
                if (exp_trig.size() == 0) begin
                    fail_note("unexpected_trigger");
                end else begin
                    e = exp_trig.pop_front();
                    check("trig_x", 32'(stepper_num_steps_x), 32'(e.x));
                    check("trig_y", 32'(stepper_num_steps_y), 32'(e.y));
                end
            end
            prev_trig = stepper_trigger;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] moves_before;
        logic [XB-1:0] rx;
        logic [YB-1:0] ry;
        reset            = 1'b0;
        clk_en           = 1'b0;
        flush            = 1'b0;
        stepper_done     = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_x     = '0;
        cmd_if.cmd_y     = '0;
        repeat (3) @(negedge clk);
        check("rst_level",   32'(level),               32'd0);
        check("rst_ready",   32'(cmd_if.cmd_ready),    32'd1);
        check("rst_busy",    32'(busy),                32'd0);
        check("rst_trigger", 32'(stepper_trigger),     32'd0);
        check("rst_x",       32'(stepper_num_steps_x), 32'd0);
        check("rst_y",       32'(stepper_num_steps_y), 32'd0);
        check("rst_moves",   32'(moves_done),          32'd0);
        reset = 1'b1;

        // single move, clk_en every 4th clk
        en_div = 4; st_dur = 5;
        push_cmd(8'h02, 8'h03);
        wait_idle();
        check("single_moves", 32'(moves_done), 32'd1);
        check("single_busy",  32'(busy),       32'd0);

        // signed sequence
        push_cmd(8'h02, 8'h03);
        push_cmd(8'h00, 8'hFB);
        push_cmd(8'hF9, 8'h04);
        push_cmd(8'hFE, 8'h00);
        wait_idle();
        check("seq_moves", 32'(moves_done), 32'd5);

        // zero-move skip
        en_div = 3; st_dur = 2;
        push_cmd(8'h00, 8'h00);
        push_cmd(8'h01, 8'h01);
        wait_idle();
        check("zero_moves", 32'(moves_done), 32'd7);

        // full / backpressure
        en_div = 2; hold_done = 1;
        tick();
        for (int i = 0; i < 4; i++) push_cmd(8'(i + 1), 8'(8'hF0 + i));
        check("full_level", 32'(level),            32'(DEPTH));
        check("full_ready", 32'(cmd_if.cmd_ready), 32'd0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_x     = 8'h55;
        cmd_if.cmd_y     = 8'hAA;
        repeat (6) tick();
        check("full_held", 32'(cmd_if.cmd_ready), 32'd0);
        hold_done = 0;
        push_cmd(8'h55, 8'hAA);
        push_cmd(8'h66, 8'h99);
        wait_idle();

        // flush with a move in flight
        st_dur = 20;
        push_cmd(8'h05, 8'h06);
        wait_phase(2);
        push_cmd(8'h11, 8'h12);
        push_cmd(8'h21, 8'h22);
        push_cmd(8'h31, 8'h32);
        begin
            int n;
            n = 0;
            while (clk_en !== 1'b1 && n < 10) begin tick(); n++; end
        end
        moves_before = m_moves;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        wait_idle();
        check("flush_moves", 32'(moves_done), 32'(moves_before + 16'd1));

        // asynchronous reset while the trigger is high
        st_dur = 3;
        push_cmd(8'h44, 8'h33);
        push_cmd(8'h12, 8'h34);
        wait_phase(1);
        check("pre_reset_trig", 32'(stepper_trigger), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_trigger", 32'(stepper_trigger), 32'd0);
        check("arst_level",   32'(level),           32'd0);
        check("arst_moves",   32'(moves_done),      32'd0);
        check("arst_busy",    32'(busy),            32'd0);
        mq.delete();
        exp_trig.delete();
        ph = 0; m_x = '0; m_y = '0; m_moves = 16'd0; st_cnt = 0;
        stepper_done = 1'b1;
        #1 reset = 1'b1;
        push_cmd(8'h7F, 8'h80);
        wait_idle();
        check("post_reset_moves", 32'(moves_done), 32'd1);

        // randomized traffic
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 2))
                0:       en_div = 0;
                1:       en_div = 1;
                default: en_div = 3;
            endcase
            st_dur = $urandom_range(1, 4);
            rx = 8'($urandom);
            ry = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin rx = '0; ry = '0; end
            push_cmd(rx, ry);
            if ($urandom_range(0, 14) == 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 8)) tick();
        end
        wait_idle();
        repeat (3) tick();
        check("trig_queue_drained", 32'(exp_trig.size()), 32'd0);
        check("final_moves", 32'(moves_done), 32'(m_moves));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
